// File: rtl/parity_checker.sv
// One-entry registered parity checker: flags beats whose parity disagrees with the data, counts errors.
// Latency 1 cycle; in_ready = !out_valid || out_ready, so a stalled output blocks intake without loss.
module parity_checker #(
   parameter int WIDTH     = 8,
   parameter int ODD       = 0,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_parity,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_err,
   output logic                 err_sticky,
   output logic [CNT_WIDTH-1:0] err_count,
   input  logic                 clr_err
);

   localparam logic                 PAR_SENSE = (ODD != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic accept;
   logic exp_parity;
   logic beat_err;
   logic acc_err;

   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign exp_parity = (^in_data) ^ PAR_SENSE;
   assign beat_err   = (exp_parity != in_parity);
   assign acc_err    = accept && beat_err;

   // A new beat always wins over a delivery in the same edge, so out_valid stays high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_err   <= beat_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // An error accepted in the clearing cycle survives the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else if (acc_err) begin
         err_sticky <= 1'b1;
         if (clr_err)
            err_count <= CNT_ONE;
         else if (err_count != CNT_MAX)
            err_count <= err_count + CNT_ONE;
      end else if (clr_err) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end
   end

endmodule

// File: tb/tb_parity_checker.sv
// Directed bench for parity_checker: even/8-bit, odd, and 2-bit-counter instances share one stimulus bus.
module tb_parity_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_parity = 1'b0;
   logic       out_ready = 1'b1;
   logic       clr_err = 1'b0;

   logic       e_in_ready, e_out_valid, e_out_err, e_sticky;
   logic [7:0] e_out_data, e_count;
   logic       o_in_ready, o_out_valid, o_out_err, o_sticky;
   logic [7:0] o_out_data, o_count;
   logic       s_in_ready, s_out_valid, s_out_err, s_sticky;
   logic [7:0] s_out_data;
   logic [1:0] s_count;

   int n_cmp = 0;
   int n_bad = 0;
   int del01 = 0;
   int del02 = 0;
   int del55 = 0;

   always #5 clk = ~clk;

   parity_checker #(.WIDTH(8), .ODD(0), .CNT_WIDTH(8)) u_even (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
      .in_data(in_data), .in_parity(in_parity), .out_valid(e_out_valid),
      .out_ready(out_ready), .out_data(e_out_data), .out_err(e_out_err),
      .err_sticky(e_sticky), .err_count(e_count), .clr_err(clr_err));

   parity_checker #(.WIDTH(8), .ODD(1), .CNT_WIDTH(8)) u_odd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready),
      .in_data(in_data), .in_parity(in_parity), .out_valid(o_out_valid),
      .out_ready(out_ready), .out_data(o_out_data), .out_err(o_out_err),
      .err_sticky(o_sticky), .err_count(o_count), .clr_err(clr_err));

   parity_checker #(.WIDTH(8), .ODD(0), .CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_parity(in_parity), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_data(s_out_data), .out_err(s_out_err),
      .err_sticky(s_sticky), .err_count(s_count), .clr_err(clr_err));

   // Inputs only change just after a rising edge, so a handshake seen here completes on the next edge.
   always @(negedge clk) begin
      if (!rst && e_out_valid && out_ready) begin
         if (e_out_data == 8'h01) del01++;
         if (e_out_data == 8'h02) del02++;
         if (e_out_data == 8'h55) del55++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic p);
      in_valid  = 1'b1;
      in_data   = d;
      in_parity = p;
   endtask

   initial begin
      #1 rst = 1'b1;
      beat(8'hFF, 1'b1);
      #2;
      chk("rst_out_valid", e_out_valid, 0);
      chk("rst_out_data", e_out_data, 0);
      chk("rst_err_count", e_count, 0);
      chk("rst_in_ready", e_in_ready, 1);
      tick();
      chk("rst_hold_valid", e_out_valid, 0);
      chk("rst_hold_count", e_count, 0);
      chk("rst_hold_sticky", e_sticky, 0);

      @(negedge clk);
      rst = 1'b0;
      beat(8'hAA, 1'b0);
      tick();
      chk("even_aa_valid", e_out_valid, 1);
      chk("even_aa_data", e_out_data, 8'hAA);
      chk("even_aa_err", e_out_err, 0);
      chk("even_aa_count", e_count, 0);
      chk("odd_aa_p0_err", o_out_err, 1);

      beat(8'hAB, 1'b0);
      tick();
      chk("even_ab_err", e_out_err, 1);
      chk("even_ab_count", e_count, 1);
      chk("even_ab_sticky", e_sticky, 1);
      chk("odd_ab_err", o_out_err, 0);

      beat(8'hAA, 1'b1);
      tick();
      chk("odd_aa_p1_err", o_out_err, 0);
      chk("even_aa_p1_count", e_count, 2);

      // Backpressure: 8'h01 held while 8'h02 waits upstream.
      beat(8'h01, 1'b1);
      tick();
      chk("bp_first_data", e_out_data, 8'h01);
      chk("bp_first_err", e_out_err, 0);
      out_ready = 1'b0;
      beat(8'h02, 1'b1);
      #1;
      chk("bp_in_ready_low", e_in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_data", e_out_data, 8'h01);
         chk("bp_hold_valid", e_out_valid, 1);
         chk("bp_hold_ready", e_in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_high", e_in_ready, 1);
      tick();
      chk("bp_second_data", e_out_data, 8'h02);
      chk("bp_second_valid", e_out_valid, 1);
      in_valid = 1'b0;
      tick();
      chk("bp_drained", e_out_valid, 0);
      chk("bp_del01", del01, 1);
      chk("bp_del02", del02, 1);
      chk("bp_count_unchanged", e_count, 2);

      // Saturation on the 2-bit counter.
      clr_err = 1'b1;
      tick();
      chk("sat_pre_clear", s_count, 0);
      clr_err = 1'b0;
      beat(8'hAB, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sat_seq", s_count, (i < 3) ? i + 1 : 3);
      end
      chk("sat_sticky", s_sticky, 1);
      in_valid = 1'b0;
      clr_err  = 1'b1;
      tick();
      chk("clr_alone_count", s_count, 0);
      chk("clr_alone_sticky", s_sticky, 0);
      clr_err = 1'b0;
      beat(8'hAB, 1'b0);
      repeat (3) tick();
      chk("sat_refill", s_count, 3);
      clr_err = 1'b1;
      tick();
      chk("clr_with_err_count", s_count, 1);
      chk("clr_with_err_sticky", s_sticky, 1);
      clr_err = 1'b0;

      // Reset with a held beat: everything clears without a clock edge.
      beat(8'h55, 1'b1);
      tick();
      chk("mid_pre_valid", e_out_valid, 1);
      chk("mid_pre_err", e_out_err, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_valid", e_out_valid, 0);
      chk("mid_data", e_out_data, 0);
      chk("mid_err", e_out_err, 0);
      chk("mid_sticky", e_sticky, 0);
      chk("mid_count", e_count, 0);
      chk("mid_in_ready", e_in_ready, 1);
      chk("mid_sat_count", s_count, 0);
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("post_rst_valid", e_out_valid, 0);
      beat(8'h0F, 1'b0);
      tick();
      chk("first_acc_valid", e_out_valid, 1);
      chk("first_acc_data", e_out_data, 8'h0F);
      chk("first_acc_err", e_out_err, 0);
      in_valid = 1'b0;
      tick();
      chk("post_rst_drained", e_out_valid, 0);
      chk("no_del55", del55, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/parity_checker.md
PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter ODD, default 0, parity sense: 0 = even, 1 = odd.
REQ-003 Parameter CNT_WIDTH, default 8, error counter width (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_data  input  WIDTH  data word from upstream parity generator.
REQ-009 in_parity  input  1  parity bit accompanying in_data.
REQ-010 out_valid  output  1  registered beat available downstream.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  WIDTH  registered copy of accepted in_data.
REQ-013 out_err  output  1  parity mismatch flag for the beat on out_data.
REQ-014 err_sticky  output  1  set by any accepted errored beat; held until cleared.
REQ-015 err_count  output  CNT_WIDTH  saturating count of accepted errored beats.
REQ-016 clr_err  input  1  synchronous clear of err_sticky and err_count.

Function
REQ-017 Accept (handshake) occurs on a rising edge where in_valid=1 and in_ready=1; deliver occurs where out_valid=1 and out_ready=1.
REQ-018 in_ready = !out_valid || out_ready (combinational); one-entry pipeline register, full throughput when out_ready=1.
REQ-019 Latency: an accepted beat appears on out_data/out_err with out_valid=1 exactly one cycle after acceptance.
REQ-020 Expected parity = XOR-reduce(in_data) when ODD=0, its inverse when ODD=1; beat error = expected != in_parity.
REQ-021 out_err registered together with out_data from the same accepted beat.
REQ-022 out_valid next = 1 on accept; else 0 on deliver; else hold.
REQ-023 While out_valid=1 and out_ready=0: out_data, out_err held stable; no new beat accepted.
REQ-024 Simultaneous deliver and accept: new beat replaces old in same edge, out_valid stays 1.
REQ-025 in_data/in_parity ignored (no state change) when no accept occurs.
REQ-026 err_count increments by 1 per accepted errored beat; at all-ones it holds (no wrap).
REQ-027 err_sticky set to 1 on any accepted errored beat.
REQ-028 clr_err=1 without an accepted errored beat in the same cycle: err_count <- 0, err_sticky <- 0.
REQ-029 clr_err=1 with an accepted errored beat in the same cycle: err_count <- 1, err_sticky <- 1 (error not lost).
REQ-030 Statistics counted at acceptance, not at delivery; out_ready has no effect on err_count.

Reset
REQ-031 rst=1 forces asynchronously: out_valid=0, out_data=0, out_err=0, err_sticky=0, err_count=0.
REQ-032 in_ready=1 throughout reset (out_valid=0); beats presented during reset are not accepted into state.
REQ-033 Reset mid-operation discards any held beat; no delivery of it after reset deasserts.
REQ-034 First accept possible on the first rising edge after rst deasserts.

Verification
REQ-035 Assert rst mid-stream with out_valid=1 -> out_valid, out_data, out_err, err_sticky, err_count all 0 immediately, without a clock edge; in_ready=1.
REQ-036 ODD=0, WIDTH=8: in_data=8'hAA, in_parity=0, out_ready=1 -> next cycle out_valid=1, out_data=8'hAA, out_err=0, err_count=0; then in_data=8'hAB, in_parity=0 -> out_err=1, err_count=1, err_sticky=1.
REQ-037 ODD=1: in_data=8'hAA, in_parity=1 -> out_err=0; in_parity=0 -> out_err=1.
REQ-038 Backpressure: accept 8'h01/parity 1, hold out_ready=0 for 3 cycles while offering 8'h02 -> in_ready=0, out_data stays 8'h01; raise out_ready -> 8'h01 delivered, then 8'h02 accepted and delivered next cycle, no loss or duplication.
REQ-039 CNT_WIDTH=2: 5 consecutive errored beats -> err_count sequence 1,2,3,3,3; clr_err alone -> err_count=0, err_sticky=0.
REQ-040 clr_err asserted in the same cycle as an errored beat is accepted with err_count=3 -> err_count=1, err_sticky=1.
